// File: rtl/axi_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter_if
// Bundles the AXI4 write-path signals around axi_wr_arbiter.
//   m_*  : NUM_M write masters, fields flattened (master i occupies slice i).
//   s_*  : the single shared memory-slave write port.
// Modports:
//   arb    - the arbiter itself (consumes master requests, drives the slave).
//   master - the write-master side (drives m_* requests, sees m_* responses).
//   slave  - the memory-slave side (drives s_* ready/B, sees s_* requests).
// -----------------------------------------------------------------------------
interface axi_wr_arbiter_if #(
    parameter int NUM_M         = 2,
    parameter int ID_WIDTH      = 1,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // master side
    logic [NUM_M-1:0]               m_aw_valid;
    logic [NUM_M-1:0]               m_aw_ready;
    logic [NUM_M*ID_WIDTH-1:0]      m_aw_id;
    logic [NUM_M*ADDRESS_WIDTH-1:0] m_aw_addr;
    logic [NUM_M*8-1:0]             m_aw_len;
    logic [NUM_M*3-1:0]             m_aw_size;
    logic [NUM_M*2-1:0]             m_aw_burst;
    logic [NUM_M-1:0]               m_w_valid;
    logic [NUM_M-1:0]               m_w_ready;
    logic [NUM_M*DATA_WIDTH-1:0]    m_w_data;
    logic [NUM_M*STRB_WIDTH-1:0]    m_w_strb;
    logic [NUM_M-1:0]               m_w_last;
    logic [NUM_M-1:0]               m_b_valid;
    logic [NUM_M-1:0]               m_b_ready;
    logic [ID_WIDTH-1:0]            m_b_id;
    logic [1:0]                     m_b_resp;

    // slave side
    logic                           s_aw_valid;
    logic                           s_aw_ready;
    logic [ID_WIDTH-1:0]            s_aw_id;
    logic [ADDRESS_WIDTH-1:0]       s_aw_addr;
    logic [7:0]                     s_aw_len;
    logic [2:0]                     s_aw_size;
    logic [1:0]                     s_aw_burst;
    logic [3:0]                     s_aw_cache;
    logic [2:0]                     s_aw_prot;
    logic [3:0]                     s_aw_qos;
    logic [3:0]                     s_aw_region;
    logic                           s_w_valid;
    logic                           s_w_ready;
    logic [DATA_WIDTH-1:0]          s_w_data;
    logic [STRB_WIDTH-1:0]          s_w_strb;
    logic                           s_w_last;
    logic                           s_b_valid;
    logic                           s_b_ready;
    logic [ID_WIDTH-1:0]            s_b_id;
    logic [1:0]                     s_b_resp;

    modport arb (
        input  m_aw_valid, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
        input  m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready,
        output m_aw_ready, m_w_ready, m_b_valid, m_b_id, m_b_resp,
        output s_aw_valid, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst,
        output s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region,
        output s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready,
        input  s_aw_ready, s_w_ready, s_b_valid, s_b_id, s_b_resp
    );

    modport master (
        output m_aw_valid, m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
        output m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready,
        input  m_aw_ready, m_w_ready, m_b_valid, m_b_id, m_b_resp
    );

    modport slave (
        input  s_aw_valid, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst,
        input  s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region,
        input  s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready,
        output s_aw_ready, s_w_ready, s_b_valid, s_b_id, s_b_resp
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter
// Round-robin arbiter sharing one AXI4 write path (AW/W/B) between NUM_M
// masters, one outstanding burst at a time. The grant is held from AW
// acceptance through the B handshake. W beats are counted against the latched
// burst length; s_w_last is regenerated from that count and any disagreement
// with the master's own w_last raises a one-cycle wlast_err pulse.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   bus       - axi_wr_arbiter_if (arb modport): master and slave channels
//   grant     - one-hot current owner, zero while idle
//   wlast_err - one-cycle pulse after a W handshake with a w_last mismatch
// -----------------------------------------------------------------------------
module axi_wr_arbiter #(
    parameter int NUM_M         = 2,
    parameter int ID_WIDTH      = 1,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 64
) (
    input  logic             clk,
    input  logic             rst,
    axi_wr_arbiter_if.arb    bus,
    output logic [NUM_M-1:0] grant,
    output logic             wlast_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_M);
    localparam int CW     = IDX_W + 1;   // room for index + offset before wrap

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

    state_e             state_q, state_d;
    logic [NUM_M-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         len_q, len_d;
    logic               wlast_err_q, wlast_err_d;

    logic                     sel_aw_valid_s, sel_w_valid_s, sel_w_last_s, sel_b_ready_s;
    logic [ID_WIDTH-1:0]      sel_aw_id_s;
    logic [ADDRESS_WIDTH-1:0] sel_aw_addr_s;
    logic [7:0]               sel_aw_len_s;
    logic [2:0]               sel_aw_size_s;
    logic [1:0]               sel_aw_burst_s;
    logic [DATA_WIDTH-1:0]    sel_w_data_s;
    logic [STRB_W-1:0]        sel_w_strb_s;
    logic                     pick_valid_s;
    logic [IDX_W-1:0]         pick_idx_s;
    logic [IDX_W-1:0]         rr_next_s;
    logic                     in_addr_s, in_data_s, in_resp_s;
    logic                     aw_hs_s, w_hs_s, b_hs_s, last_beat_s;

    assign in_addr_s   = (state_q == ST_ADDR);
    assign in_data_s   = (state_q == ST_DATA);
    assign in_resp_s   = (state_q == ST_RESP);
    assign last_beat_s = (beat_cnt_q == len_q);
    assign aw_hs_s     = in_addr_s & sel_aw_valid_s & bus.s_aw_ready;
    assign w_hs_s      = in_data_s & sel_w_valid_s & bus.s_w_ready;
    assign b_hs_s      = in_resp_s & bus.s_b_valid & sel_b_ready_s;

    // Select the granted master's request fields (AND-OR mux over all slices).
    always_comb begin
        logic hit;
        hit            = 1'b0;
        sel_aw_valid_s = 1'b0;
        sel_w_valid_s  = 1'b0;
        sel_w_last_s   = 1'b0;
        sel_b_ready_s  = 1'b0;
        sel_aw_id_s    = '0;
        sel_aw_addr_s  = '0;
        sel_aw_len_s   = 8'd0;
        sel_aw_size_s  = 3'd0;
        sel_aw_burst_s = 2'd0;
        sel_w_data_s   = '0;
        sel_w_strb_s   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            hit            = (gidx_q == IDX_W'(i));
            sel_aw_valid_s = sel_aw_valid_s | (bus.m_aw_valid[i] & hit);
            sel_w_valid_s  = sel_w_valid_s  | (bus.m_w_valid[i]  & hit);
            sel_w_last_s   = sel_w_last_s   | (bus.m_w_last[i]   & hit);
            sel_b_ready_s  = sel_b_ready_s  | (bus.m_b_ready[i]  & hit);
            sel_aw_id_s    = sel_aw_id_s    | (bus.m_aw_id[i*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{hit}});
            sel_aw_addr_s  = sel_aw_addr_s  | (bus.m_aw_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{hit}});
            sel_aw_len_s   = sel_aw_len_s   | (bus.m_aw_len[i*8 +: 8] & {8{hit}});
            sel_aw_size_s  = sel_aw_size_s  | (bus.m_aw_size[i*3 +: 3] & {3{hit}});
            sel_aw_burst_s = sel_aw_burst_s | (bus.m_aw_burst[i*2 +: 2] & {2{hit}});
            sel_w_data_s   = sel_w_data_s   | (bus.m_w_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hit}});
            sel_w_strb_s   = sel_w_strb_s   | (bus.m_w_strb[i*STRB_W +: STRB_W] & {STRB_W{hit}});
        end
    end

    // Round-robin pick: first AW requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [CW-1:0] cand;
        logic          take;
        logic [CW-1:0] inc;
        cand         = '0;
        take         = 1'b0;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            cand         = {1'b0, rr_ptr_q} + CW'(k);
            cand         = (cand >= CW'(NUM_M)) ? (cand - CW'(NUM_M)) : cand;
            take         = ~pick_valid_s & bus.m_aw_valid[cand[IDX_W-1:0]];
            pick_idx_s   = take ? cand[IDX_W-1:0] : pick_idx_s;
            pick_valid_s = pick_valid_s | take;
        end
        inc       = {1'b0, gidx_q} + CW'(1);
        inc       = (inc >= CW'(NUM_M)) ? CW'(0) : inc;
        rr_next_s = inc[IDX_W-1:0];
    end

    // Next-state logic for the burst FSM and its bookkeeping registers.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        wlast_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_d = {{(NUM_M-1){1'b0}}, 1'b1} << pick_idx_s;
                    gidx_d  = pick_idx_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (aw_hs_s) begin
                    len_d      = sel_aw_len_s;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (w_hs_s) begin
                    // The counter, not the master's w_last, decides the end.
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    wlast_err_d = (sel_w_last_s != last_beat_s);
                    state_d     = last_beat_s ? ST_RESP : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (b_hs_s) begin
                    rr_ptr_d = rr_next_s;
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= 8'd0;
            len_q       <= 8'd0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // Per-master handshakes reach only the granted master; grant_q is the mask.
    assign bus.m_aw_ready = grant_q & {NUM_M{in_addr_s & bus.s_aw_ready}};
    assign bus.m_w_ready  = grant_q & {NUM_M{in_data_s & bus.s_w_ready}};
    assign bus.m_b_valid  = grant_q & {NUM_M{in_resp_s & bus.s_b_valid}};
    assign bus.m_b_id     = in_resp_s ? bus.s_b_id : '0;
    assign bus.m_b_resp   = in_resp_s ? bus.s_b_resp : 2'b00;

    assign bus.s_aw_valid  = in_addr_s & sel_aw_valid_s;
    assign bus.s_aw_id     = in_addr_s ? sel_aw_id_s : '0;
    assign bus.s_aw_addr   = in_addr_s ? sel_aw_addr_s : '0;
    assign bus.s_aw_len    = in_addr_s ? sel_aw_len_s : 8'd0;
    assign bus.s_aw_size   = in_addr_s ? sel_aw_size_s : 3'd0;
    assign bus.s_aw_burst  = in_addr_s ? sel_aw_burst_s : 2'd0;
    assign bus.s_aw_cache  = 4'b0011;
    assign bus.s_aw_prot   = 3'b000;
    assign bus.s_aw_qos    = 4'h0;
    assign bus.s_aw_region = 4'h0;

    assign bus.s_w_valid = in_data_s & sel_w_valid_s;
    assign bus.s_w_data  = in_data_s ? sel_w_data_s : '0;
    assign bus.s_w_strb  = in_data_s ? sel_w_strb_s : '0;
    assign bus.s_w_last  = in_data_s & last_beat_s;
    assign bus.s_b_ready = in_resp_s & sel_b_ready_s;

    assign grant     = grant_q;
    assign wlast_err = wlast_err_q;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_arbiter
// Directed bench for axi_wr_arbiter with two masters: a per-cycle vector table
// for a complete burst to each master, followed by hand-written sequences for
// fairness, W back-pressure, w_last mismatch and reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_axi_wr_arbiter;
    localparam int NUM_M         = 2;
    localparam int ID_WIDTH      = 1;
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 64;
    localparam logic [31:0] ADDR0 = 32'h0000_0100;
    localparam logic [31:0] ADDR1 = 32'h0000_0200;
    localparam logic [63:0] DATA0 = 64'hA0A0_0000_1111_0000;
    localparam logic [63:0] DATA1 = 64'hB1B1_0000_2222_0001;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       wlast_err;
    int         n_checks = 0;
    int         n_errors = 0;

    axi_wr_arbiter_if #(.NUM_M(NUM_M), .ID_WIDTH(ID_WIDTH),
                        .ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axi_wr_arbiter #(.NUM_M(NUM_M), .ID_WIDTH(ID_WIDTH),
                     .ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant     (grant),
        .wlast_err (wlast_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0] aw_v;     logic w_v;     logic w_l;     logic saw_r;
        logic       sw_r;     logic sb_v;    logic [1:0] mb_r;  logic [1:0] sb_resp;
        logic [1:0] e_grant;  logic e_saw_v; logic [1:0] e_aw_rdy;
        logic       e_sw_v;   logic [1:0] e_w_rdy;  logic e_sw_l;
        logic [1:0] e_mb_v;   logic e_sb_r;  logic e_err;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.m_aw_valid = 2'b00;
        bus.m_w_valid  = 2'b00;
        bus.m_w_last   = 2'b00;
        bus.m_b_ready  = 2'b00;
        bus.s_aw_ready = 1'b0;
        bus.s_w_ready  = 1'b0;
        bus.s_b_valid  = 1'b0;
        bus.s_b_resp   = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        quiet_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_grant"},   grant, 2'b00);
        chk({tag, "_saw_v"},   bus.s_aw_valid, 1'b0);
        chk({tag, "_maw_rdy"}, bus.m_aw_ready, 2'b00);
        chk({tag, "_sw_v"},    bus.s_w_valid, 1'b0);
        chk({tag, "_mw_rdy"},  bus.m_w_ready, 2'b00);
        chk({tag, "_mb_v"},    bus.m_b_valid, 2'b00);
        chk({tag, "_sb_rdy"},  bus.s_b_ready, 1'b0);
        chk({tag, "_err"},     wlast_err, 1'b0);
    endtask

    initial begin
        logic [1:0] fair_exp [4];
        logic [1:0] prev_g;
        int         got;
        int         n_hs;
        logic       err_seen;
        logic       hit;
        vec_t       v;

        // aw_v w_v w_l saw_r sw_r sb_v mb_r resp | grant saw_v aw_rdy sw_v w_rdy sw_l mb_v sb_r err
        tbl[0]  = '{2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00, 2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0};
        tbl[1]  = '{2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00, 2'b01,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0};
        tbl[2]  = '{2'b11,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00, 2'b01,1'b1,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0};
        tbl[3]  = '{2'b10,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,1'b0,2'b00,1'b1,2'b01,1'b0,2'b00,1'b0,1'b0};
        tbl[4]  = '{2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00, 2'b01,1'b0,2'b00,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0};
        tbl[5]  = '{2'b10,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,1'b0,2'b00,1'b1,2'b01,1'b0,2'b00,1'b0,1'b0};
        tbl[6]  = '{2'b10,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,1'b0,2'b00,1'b0,2'b01,1'b0,2'b00,1'b0,1'b0};
        tbl[7]  = '{2'b10,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,1'b0,2'b00,1'b1,2'b01,1'b0,2'b00,1'b0,1'b0};
        tbl[8]  = '{2'b10,1'b1,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00, 2'b01,1'b0,2'b00,1'b1,2'b01,1'b1,2'b00,1'b0,1'b0};
        tbl[9]  = '{2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00, 2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0};
        tbl[10] = '{2'b10,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,2'b00, 2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b01,1'b1,1'b0};
        tbl[11] = '{2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00, 2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0};
        tbl[12] = '{2'b10,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00, 2'b10,1'b1,2'b10,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0};
        tbl[13] = '{2'b01,1'b1,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00, 2'b10,1'b0,2'b00,1'b1,2'b10,1'b1,2'b00,1'b0,1'b0};
        tbl[14] = '{2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,2'b10, 2'b10,1'b0,2'b00,1'b0,2'b00,1'b0,2'b10,1'b1,1'b0};
        tbl[15] = '{2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00, 2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0};
        fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;

        // Static master payloads: master 0 len 3, master 1 len 0.
        bus.m_aw_id    = 2'b10;
        bus.m_aw_addr  = {ADDR1, ADDR0};
        bus.m_aw_len   = {8'd0, 8'd3};
        bus.m_aw_size  = {3'd3, 3'd3};
        bus.m_aw_burst = {2'b01, 2'b01};
        bus.m_w_data   = {DATA1, DATA0};
        bus.m_w_strb   = 16'hFFFF;
        bus.s_b_id     = 1'b1;

        // ---- Reset held with every master requesting
        rst = 1'b0;
        quiet_inputs();
        bus.m_aw_valid = 2'b11;
        bus.m_w_valid  = 2'b11;
        bus.m_b_ready  = 2'b11;
        bus.s_aw_ready = 1'b1;
        bus.s_w_ready  = 1'b1;
        bus.s_b_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_quiet("rst");
        @(negedge clk);
        rst = 1'b1;

        // ---- Vector table: burst to master 0 (len 3, stalls), then master 1
        for (int s = 0; s < 16; s++) begin
            v = tbl[s];
            bus.m_aw_valid = v.aw_v;
            bus.m_w_valid  = {2{v.w_v}};
            bus.m_w_last   = {2{v.w_l}};
            bus.s_aw_ready = v.saw_r;
            bus.s_w_ready  = v.sw_r;
            bus.s_b_valid  = v.sb_v;
            bus.m_b_ready  = v.mb_r;
            bus.s_b_resp   = v.sb_resp;
            #1;
            chk($sformatf("t%0d_grant", s),  grant, v.e_grant);
            chk($sformatf("t%0d_saw_v", s),  bus.s_aw_valid, v.e_saw_v);
            chk($sformatf("t%0d_awrdy", s),  bus.m_aw_ready, v.e_aw_rdy);
            chk($sformatf("t%0d_sw_v", s),   bus.s_w_valid, v.e_sw_v);
            chk($sformatf("t%0d_wrdy", s),   bus.m_w_ready, v.e_w_rdy);
            chk($sformatf("t%0d_sw_last", s), bus.s_w_last, v.e_sw_l);
            chk($sformatf("t%0d_mb_v", s),   bus.m_b_valid, v.e_mb_v);
            chk($sformatf("t%0d_sb_rdy", s), bus.s_b_ready, v.e_sb_r);
            chk($sformatf("t%0d_err", s),    wlast_err, v.e_err);
            if (v.e_saw_v) begin
                chk($sformatf("t%0d_awaddr", s), bus.s_aw_addr, (v.e_grant == 2'b10) ? ADDR1 : ADDR0);
                chk($sformatf("t%0d_awlen", s),  bus.s_aw_len,  (v.e_grant == 2'b10) ? 8'd0 : 8'd3);
                chk($sformatf("t%0d_awid", s),   bus.s_aw_id,   (v.e_grant == 2'b10) ? 1'b1 : 1'b0);
                chk($sformatf("t%0d_awcache", s), bus.s_aw_cache, 4'b0011);
            end
            if (v.e_sw_v) begin
                chk($sformatf("t%0d_wdata", s), bus.s_w_data, (v.e_grant == 2'b10) ? DATA1 : DATA0);
            end
            if (v.e_mb_v != 2'b00) begin
                chk($sformatf("t%0d_bresp", s), bus.m_b_resp, v.sb_resp);
                chk($sformatf("t%0d_bid", s),   bus.m_b_id, 1'b1);
            end
            @(negedge clk);
        end

        // ---- Fairness: both request continuously with single-beat bursts
        do_reset();
        bus.m_aw_len   = {8'd0, 8'd0};
        bus.m_aw_valid = 2'b11;
        bus.m_w_valid  = 2'b11;
        bus.m_w_last   = 2'b11;
        bus.s_aw_ready = 1'b1;
        bus.s_w_ready  = 1'b1;
        bus.s_b_valid  = 1'b1;
        bus.m_b_ready  = 2'b11;
        prev_g = 2'b00;
        got    = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            #1;
            if (grant != 2'b00 && prev_g == 2'b00) begin
                chk($sformatf("fair_grant%0d", got), grant, fair_exp[got]);
                got++;
            end
            prev_g = grant;
        end
        chk("fair_count", got, 4);

        // ---- Back-pressure: len 7 burst with s_w_ready toggling
        do_reset();
        bus.m_aw_len   = {8'd0, 8'd7};
        bus.m_aw_valid = 2'b01;
        bus.m_w_valid  = 2'b01;
        bus.s_aw_ready = 1'b1;
        bus.m_b_ready  = 2'b01;
        n_hs     = 0;
        err_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.s_w_ready = ((c % 2) == 0);
            bus.m_w_last  = {1'b0, (n_hs == 7)};
            #1;
            err_seen = err_seen | wlast_err;
            if (bus.s_w_valid) begin
                chk($sformatf("bp_last_at%0d", n_hs), bus.s_w_last, (n_hs == 7));
                if (bus.s_w_ready) begin
                    n_hs++;
                end
            end
        end
        chk("bp_beats", n_hs, 8);
        chk("bp_err", err_seen, 1'b0);
        chk("bp_resp_grant", grant, 2'b01);
        chk("bp_resp_mbv", bus.m_b_valid, 2'b00);
        @(negedge clk);
        bus.s_b_valid = 1'b1;
        bus.m_aw_valid = 2'b00;
        #1;
        chk("bp_mbv", bus.m_b_valid, 2'b01);
        @(negedge clk);
        bus.s_b_valid = 1'b0;
        #1;
        chk("bp_idle_grant", grant, 2'b00);

        // ---- w_last mismatch: len 1, master asserts w_last on both beats
        do_reset();
        bus.m_aw_len   = {8'd0, 8'd1};
        bus.m_aw_valid = 2'b01;
        bus.m_w_valid  = 2'b01;
        bus.m_w_last   = 2'b01;
        bus.s_aw_ready = 1'b1;
        bus.s_w_ready  = 1'b1;
        @(negedge clk);
        #1;
        chk("wl_addr_grant", grant, 2'b01);
        chk("wl_addr_err", wlast_err, 1'b0);
        @(negedge clk);
        #1;
        chk("wl_b0_sw_v", bus.s_w_valid, 1'b1);
        chk("wl_b0_last", bus.s_w_last, 1'b0);
        chk("wl_b0_err", wlast_err, 1'b0);
        @(negedge clk);
        #1;
        chk("wl_b1_err", wlast_err, 1'b1);
        chk("wl_b1_last", bus.s_w_last, 1'b1);
        @(negedge clk);
        #1;
        chk("wl_after_err", wlast_err, 1'b0);
        chk("wl_after_sw_v", bus.s_w_valid, 1'b0);

        // ---- Reset during beat 2 of master 1's burst (rr_ptr is 1 by then)
        do_reset();
        bus.m_aw_len   = {8'd3, 8'd0};
        bus.m_aw_valid = 2'b11;
        bus.m_w_valid  = 2'b11;
        bus.m_w_last   = 2'b01;
        bus.s_aw_ready = 1'b1;
        bus.s_w_ready  = 1'b1;
        bus.s_b_valid  = 1'b1;
        bus.m_b_ready  = 2'b11;
        n_hs = 0;
        hit  = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (grant == 2'b10 && bus.s_w_valid) begin
                if (n_hs == 2) begin
                    hit = 1'b1;
                end else begin
                    n_hs++;
                end
            end
        end
        chk("mr_reached_beat2", hit, 1'b1);
        rst = 1'b0;
        #1;
        chk_all_quiet("mr_inrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_regrant", grant, 2'b01);
        chk("mr_sw_v", bus.s_w_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
